px_out_packer: RTL and testbench

PX_OUT_PACKER -- requirements
Module: px_out_packer

---
 rtl/sobel_pkg.sv | 16 +
 rtl/px_word_fifo.sv | 55 +++++
 rtl/px_out_packer.sv | 134 +++++++++++++
 tb/tb_px_out_packer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared sobel widths and packer state encoding
package sobel_pkg;

  localparam int PIXEL_WIDTH_OUT = 8;
  localparam int WORD_WIDTH      = 4 * PIXEL_WIDTH_OUT;
  // One FIFO entry: {last, bytes[2:0], word}
  localparam int PACK_ENTRY_W    = WORD_WIDTH + 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } pack_state_e;

endpackage

// File: rtl/px_word_fifo.sv
// rtl/px_word_fifo.sv - first-word-fall-through FIFO for packed words
module px_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Fullness comes from the registered count only, so a pop in the same
  // cycle never makes room for a push.
  assign empty_o    = (count == '0);
  assign full_o     = (count == (AW+1)'(DEPTH));
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem[rd_ptr];

  // Storage array; contents are don't-care until pointed at by a valid entry
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/px_out_packer.sv
// rtl/px_out_packer.sv - packs processed pixels into 32-bit words with frame flush
module px_out_packer
  import sobel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       start_i,
  input  logic                       finish_i,
  input  logic                       px_valid_i,
  input  logic [PIXEL_WIDTH_OUT-1:0] px_data_i,
  input  logic                       word_ready_i,
  output logic [WORD_WIDTH-1:0]      word_o,
  output logic                       word_valid_o,
  output logic [2:0]                 word_bytes_o,
  output logic                       word_last_o,
  output logic [15:0]                px_count_o,
  output logic                       overflow_o,
  output logic                       busy_o,
  output logic                       done_o
);

  pack_state_e             state_q, state_d;
  logic [WORD_WIDTH-1:0]   acc_q, acc_wr;
  logic [2:0]              fill_q, fill_inc;
  logic                    px_take;
  logic                    word_complete;
  logic                    flush_push;
  logic                    fifo_push;
  logic [PACK_ENTRY_W-1:0] fifo_wdata;
  logic [PACK_ENTRY_W-1:0] fifo_head;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    fifo_pop;

  // fill_q counts lanes 0..4 so a flush can report a full word when the
  // fourth pixel arrives together with finish_i.
  assign px_take       = (state_q == ST_PACK) && px_valid_i;
  assign fill_inc      = fill_q + 3'd1;
  assign word_complete = px_take && (fill_inc == 3'd4) && !finish_i;
  assign flush_push    = (state_q == ST_FLUSH) && !fifo_full;
  assign fifo_push     = word_complete || flush_push;
  assign fifo_wdata    = flush_push ? {1'b1, fill_q, acc_q} : {1'b0, 3'd4, acc_wr};

  // Accumulator with the incoming pixel dropped into the current lane
  always_comb begin
    acc_wr = acc_q;
    acc_wr[{fill_q[1:0], 3'b000} +: PIXEL_WIDTH_OUT] = px_data_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_PACK;
      ST_PACK:  if (finish_i) state_d = ST_FLUSH;
      ST_FLUSH: if (!fifo_full) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_pop && fifo_head[PACK_ENTRY_W-1]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Lane accumulation, pixel counting and sticky overflow
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      acc_q      <= '0;
      fill_q     <= '0;
      px_count_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            acc_q      <= '0;
            fill_q     <= '0;
            px_count_o <= '0;
            overflow_o <= 1'b0;
          end
        end
        ST_PACK: begin
          if (px_take) begin
            if (px_count_o != 16'hFFFF) px_count_o <= px_count_o + 16'd1;
            if (word_complete) begin
              acc_q  <= '0;
              fill_q <= '0;
              if (fifo_full) overflow_o <= 1'b1;
            end else begin
              acc_q  <= acc_wr;
              fill_q <= fill_inc;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_push) begin
            acc_q  <= '0;
            fill_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  px_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PACK_ENTRY_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Head fields are masked while empty so stale storage never reaches outputs
  assign word_valid_o = !fifo_empty;
  assign fifo_pop     = word_valid_o && word_ready_i;
  assign word_o       = fifo_empty ? '0 : fifo_head[WORD_WIDTH-1:0];
  assign word_bytes_o = fifo_empty ? '0 : fifo_head[WORD_WIDTH+2:WORD_WIDTH];
  assign word_last_o  = fifo_empty ? 1'b0 : fifo_head[PACK_ENTRY_W-1];
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DRAIN) && fifo_pop && fifo_head[PACK_ENTRY_W-1];

endmodule

// File: tb/tb_px_out_packer.sv
// tb/tb_px_out_packer.sv - directed self-checking bench for px_out_packer
module tb_px_out_packer;

  logic        clk_i = 1'b0;
  logic        nreset_i = 1'b0;
  logic        start_i = 1'b0;
  logic        finish_i = 1'b0;
  logic        px_valid_i = 1'b0;
  logic [7:0]  px_data_i = '0;
  logic        word_ready_i = 1'b0;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic [2:0]  word_bytes_o;
  logic        word_last_o;
  logic [15:0] px_count_o;
  logic        overflow_o;
  logic        busy_o;
  logic        done_o;

  int vectors = 0;
  int miscompares = 0;
  logic [35:0] cap_q[$];
  int done_cnt = 0;

  px_out_packer #(.FIFO_DEPTH(4)) dut (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .start_i      (start_i),
    .finish_i     (finish_i),
    .px_valid_i   (px_valid_i),
    .px_data_i    (px_data_i),
    .word_ready_i (word_ready_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_bytes_o (word_bytes_o),
    .word_last_o  (word_last_o),
    .px_count_o   (px_count_o),
    .overflow_o   (overflow_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  // capture every handshake and done pulse at the active edge
  always @(posedge clk_i) begin
    if (word_valid_o && word_ready_i) cap_q.push_back({word_last_o, word_bytes_o, word_o});
    if (done_o) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_px(input logic [7:0] d);
    px_valid_i = 1'b1;
    px_data_i  = d;
    tick();
    px_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_finish();
    finish_i = 1'b1;
    tick();
    finish_i = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    nreset_i = 1'b0;
    tick(); tick();
    vectors++;
    if ({word_valid_o, busy_o, overflow_o, done_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000", {word_valid_o, busy_o, overflow_o, done_o});
    end
    vectors++;
    if (px_count_o !== 16'd0 || word_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data got count=%h word=%h want 0/0", px_count_o, word_o);
    end
    nreset_i = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    cap_q.delete(); done_cnt = 0;
    word_ready_i = 1'b1;
    pulse_start();
    send_px(8'h11); send_px(8'h22); send_px(8'h33); send_px(8'h44); send_px(8'h55);
    pulse_finish();
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL basic_timeout busy=%b want 0", busy_o); end
    vectors++;
    if (cap_q.size() != 2) begin
      miscompares++; $display("FAIL basic_nwords got %0d want 2", cap_q.size());
    end else begin
      vectors++;
      if (cap_q[0] !== {1'b0, 3'd4, 32'h44332211}) begin
        miscompares++; $display("FAIL basic_word0 got %h want %h", cap_q[0], {1'b0, 3'd4, 32'h44332211});
      end
      vectors++;
      if (cap_q[1] !== {1'b1, 3'd1, 32'h00000055}) begin
        miscompares++; $display("FAIL basic_word1 got %h want %h", cap_q[1], {1'b1, 3'd1, 32'h00000055});
      end
    end
    vectors++;
    if (done_cnt != 1 || px_count_o !== 16'd5) begin
      miscompares++; $display("FAIL basic_done_count got done=%0d count=%0d want 1/5", done_cnt, px_count_o);
    end
  endtask

  task automatic test_terminator();
    bit ok;
    cap_q.delete(); done_cnt = 0;
    word_ready_i = 1'b1;
    pulse_start();
    for (int i = 1; i <= 8; i++) send_px(8'(i));
    pulse_finish();
    wait_idle(ok);
    vectors++;
    if (!ok || cap_q.size() != 3) begin
      miscompares++; $display("FAIL term_nwords got %0d ok=%b want 3/1", cap_q.size(), ok);
    end else begin
      vectors++;
      if (cap_q[0] !== {4'b0100, 32'h04030201} || cap_q[1] !== {4'b0100, 32'h08070605}) begin
        miscompares++; $display("FAIL term_full got %h %h want 404030201 408070605", cap_q[0], cap_q[1]);
      end
      vectors++;
      if (cap_q[2] !== {1'b1, 3'd0, 32'h0}) begin
        miscompares++; $display("FAIL term_last got %h want 800000000", cap_q[2]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    cap_q.delete(); done_cnt = 0;
    word_ready_i = 1'b0;
    pulse_start();
    for (int i = 1; i <= 20; i++) begin
      send_px(8'(i));
      if (i > 4 && (word_o !== 32'h04030201 || word_bytes_o !== 3'd4 || !word_valid_o)) begin
        vectors++; miscompares++;
        $display("FAIL ovf_stable got %h bytes %0d at px %0d want 04030201/4", word_o, word_bytes_o, i);
      end
    end
    vectors++;
    if (overflow_o !== 1'b1 || px_count_o !== 16'd20) begin
      miscompares++; $display("FAIL ovf_flags got ovf=%b count=%0d want 1/20", overflow_o, px_count_o);
    end
    pulse_finish();
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (busy_o !== 1'b1 || word_o !== 32'h04030201) begin
      miscompares++; $display("FAIL ovf_flush_wait got busy=%b word=%h want 1/04030201", busy_o, word_o);
    end
    word_ready_i = 1'b1;
    wait_idle(ok);
    vectors++;
    if (!ok || cap_q.size() != 5) begin
      miscompares++; $display("FAIL ovf_nwords got %0d ok=%b want 5/1", cap_q.size(), ok);
    end else begin
      vectors++;
      if (cap_q[3] !== {4'b0100, 32'h100F0E0D} || cap_q[4] !== {4'b1000, 32'h0}) begin
        miscompares++; $display("FAIL ovf_tail got %h %h want 4100f0e0d 800000000", cap_q[3], cap_q[4]);
      end
    end
  endtask

  task automatic test_finish_same_cycle();
    bit ok;
    cap_q.delete(); done_cnt = 0;
    word_ready_i = 1'b1;
    pulse_start();
    send_px(8'hA1); send_px(8'hA2); send_px(8'hA3);
    finish_i = 1'b1;
    send_px(8'hA4);
    finish_i = 1'b0;
    wait_idle(ok);
    vectors++;
    if (!ok || cap_q.size() != 1) begin
      miscompares++; $display("FAIL same_nwords got %0d ok=%b want 1/1", cap_q.size(), ok);
    end else begin
      vectors++;
      if (cap_q[0] !== {1'b1, 3'd4, 32'hA4A3A2A1}) begin
        miscompares++; $display("FAIL same_word got %h want ca4a3a2a1", cap_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    word_ready_i = 1'b0;
    pulse_start();
    for (int i = 1; i <= 6; i++) send_px(8'(i));
    nreset_i = 1'b0;
    tick();
    vectors++;
    if (word_valid_o !== 1'b0 || busy_o !== 1'b0 || px_count_o !== 16'd0) begin
      miscompares++; $display("FAIL midreset got valid=%b busy=%b count=%0d want 0/0/0", word_valid_o, busy_o, px_count_o);
    end
    nreset_i = 1'b1;
    tick();
    cap_q.delete(); done_cnt = 0;
    word_ready_i = 1'b1;
    pulse_start();
    send_px(8'h01); send_px(8'h02);
    pulse_finish();
    wait_idle(ok);
    vectors++;
    if (!ok || cap_q.size() != 1 || cap_q[0] !== {1'b1, 3'd2, 32'h00000201}) begin
      miscompares++; $display("FAIL midreset_restart got n=%0d ok=%b want a00000201", cap_q.size(), ok);
    end
  endtask

  task automatic test_ignored();
    bit ok;
    cap_q.delete(); done_cnt = 0;
    word_ready_i = 1'b1;
    send_px(8'hEE); send_px(8'hEF);
    pulse_finish();
    vectors++;
    if (busy_o !== 1'b0 || px_count_o !== 16'd2 || word_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL idle_ignore got busy=%b count=%0d valid=%b want 0/2/0", busy_o, px_count_o, word_valid_o);
    end
    pulse_start();
    send_px(8'h31); send_px(8'h32); send_px(8'h33);
    pulse_start();
    vectors++;
    if (busy_o !== 1'b1 || px_count_o !== 16'd3) begin
      miscompares++; $display("FAIL pack_start_ignore got busy=%b count=%0d want 1/3", busy_o, px_count_o);
    end
    send_px(8'h34); send_px(8'h35);
    pulse_finish();
    wait_idle(ok);
    vectors++;
    if (!ok || cap_q.size() != 2 || cap_q[0] !== {4'b0100, 32'h34333231} || cap_q[1] !== {4'b1001, 32'h35}) begin
      miscompares++; $display("FAIL pack_start_words got n=%0d ok=%b want 434333231 900000035", cap_q.size(), ok);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_terminator();
    test_overflow();
    test_finish_same_cycle();
    test_reset_mid();
    test_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
